bwd_mem_req_merge: RTL and testbench

Parametrised multi-lane successor to the single-lane backward datapath memory-request interface. It collects (addr_k, addr_l) request pairs from LANES independent backward datapaths into per-lane FIFOs. It serialises them round-robin onto one ready/valid memory-request port, with a tag identifying lane, read and k/l half. It sits between the backward datapath instances and the shared BWT occurrence-memory request channel.

---
 rtl/bwd_req_pkg.sv | 26 ++
 rtl/bwd_req_fifo.sv | 52 +++++
 rtl/bwd_mem_req_merge.sv | 194 +++++++++++++++++++
 tb/tb_bwd_mem_req_merge.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bwd_req_pkg.sv
// rtl/bwd_req_pkg.sv - shared types and constants for the backward memory-request merge
package bwd_req_pkg;

  // Request sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE_K = 2'd1,
    ST_ISSUE_L = 2'd2
  } req_state_t;

  // Kind field of the memory-request tag
  localparam logic [1:0] KIND_K  = 2'b00;
  localparam logic [1:0] KIND_L  = 2'b01;
  localparam logic [1:0] KIND_KL = 2'b10;

  // Status encodings shared with the backward datapath
  localparam logic [1:0] BCK_INI = 2'd0;
  localparam logic [1:0] BCK_RUN = 2'd1;
  localparam logic [1:0] BCK_END = 2'd2;

  // Lane-id field width; a single lane still carries a 1-bit id
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/bwd_req_fifo.sv
// rtl/bwd_req_fifo.sv - single-lane request FIFO with occupancy and look-ahead head
module bwd_req_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 94,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [W-1:0]  head_next,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  // head_next lets the arbiter re-grant this lane in the same cycle it pops
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  // Storage has no reset; its contents only matter while count is non-zero
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bwd_mem_req_merge.sv
// rtl/bwd_mem_req_merge.sv - round-robin merge of per-lane k/l request pairs; optional BWD_DEDUP_KL_EN
module bwd_mem_req_merge
  import bwd_req_pkg::*;
#(
  parameter  int LANES     = 4,
  parameter  int ADDR_W    = 42,
  parameter  int RN_W      = 10,
  parameter  int DEPTH     = 8,
  parameter  int AF_MARGIN = 2,
  localparam int LW        = lane_w(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       lane_req_valid,
  input  logic [LANES*ADDR_W-1:0] lane_addr_k,
  input  logic [LANES*ADDR_W-1:0] lane_addr_l,
  input  logic [LANES*RN_W-1:0]  lane_read_num,
  output logic [LANES-1:0]       lane_almost_full,
  output logic [LANES-1:0]       overflow_err,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  output logic [LW+RN_W+1:0]     mem_req_tag,
  output logic [31:0]            req_count,
  output logic                   busy
);

  localparam int EW = RN_W + 2 * ADDR_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]    fifo_head  [LANES];
  logic [EW-1:0]    fifo_next  [LANES];
  logic [CW-1:0]    fifo_count [LANES];
  logic [LANES-1:0] fifo_full;
  logic [LANES-1:0] fifo_empty;
  logic [LANES-1:0] fifo_pop;
  logic [LANES-1:0] post_ne;

  req_state_t        state;
  logic [LW-1:0]     sel_lane;
  logic [LW-1:0]     rr_ptr;
  logic [RN_W-1:0]   out_rn;
  logic [1:0]        out_kind;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] lat_addr_l;

  logic              hs;
  logic              pair_done;
  logic              any_ne;
  logic              any_post;
  logic [LW-1:0]     win_idle;
  logic [LW-1:0]     win_post;
  logic [LW-1:0]     lat_lane;
  logic [EW-1:0]     lat_entry;
  logic [RN_W-1:0]   lat_rn;
  logic [ADDR_W-1:0] lat_k;
  logic [ADDR_W-1:0] lat_l;
  logic [1:0]        lat_kind;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bwd_req_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (lane_req_valid[i]),
      .pop       (fifo_pop[i]),
      .wdata     ({lane_read_num[i*RN_W +: RN_W],
                   lane_addr_k[i*ADDR_W +: ADDR_W],
                   lane_addr_l[i*ADDR_W +: ADDR_W]}),
      .head      (fifo_head[i]),
      .head_next (fifo_next[i]),
      .count     (fifo_count[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );

    assign lane_almost_full[i] = (fifo_count[i] >= CW'(DEPTH - AF_MARGIN));
    assign fifo_pop[i]         = pair_done && (sel_lane == LW'(i));
    // Occupancy as it will be after the current pair pops; same-cycle pushes are not counted
    assign post_ne[i]          = (sel_lane == LW'(i)) ? (fifo_count[i] > CW'(1)) : ~fifo_empty[i];
  end

  assign hs = mem_req_valid & mem_req_ready;

`ifdef BWD_DEDUP_KL_EN
  assign pair_done = hs && ((state == ST_ISSUE_L) ||
                            ((state == ST_ISSUE_K) && (out_kind == KIND_KL)));
`else
  assign pair_done = hs && (state == ST_ISSUE_L);
`endif

  assign mem_req_addr = out_addr;
  assign mem_req_tag  = {sel_lane, out_rn, out_kind};
  assign busy         = (state != ST_IDLE) | any_ne;

  // Round-robin search: first candidate after the pointer wins, pointer lane itself is last
  always_comb begin
    int idx_i;
    int idx_p;
    idx_i    = 0;
    idx_p    = 0;
    win_idle = '0;
    win_post = '0;
    any_ne   = |(~fifo_empty);
    any_post = |post_ne;
    for (int k = LANES; k >= 1; k--) begin
      idx_i = (int'(rr_ptr) + k) % LANES;
      idx_p = (int'(sel_lane) + k) % LANES;
      if (!fifo_empty[idx_i[LW-1:0]]) win_idle = idx_i[LW-1:0];
      if (post_ne[idx_p[LW-1:0]])     win_post = idx_p[LW-1:0];
    end
  end

  // Pick the entry to latch: a fresh head from idle, or the post-pop winner when chaining pairs
  always_comb begin
    if (state == ST_IDLE) begin
      lat_lane  = win_idle;
      lat_entry = fifo_head[win_idle];
    end else begin
      lat_lane  = win_post;
      lat_entry = (win_post == sel_lane) ? fifo_next[win_post] : fifo_head[win_post];
    end
    lat_rn = lat_entry[EW-1 -: RN_W];
    lat_k  = lat_entry[2*ADDR_W-1 -: ADDR_W];
    lat_l  = lat_entry[ADDR_W-1:0];
`ifdef BWD_DEDUP_KL_EN
    lat_kind = (lat_k == lat_l) ? KIND_KL : KIND_K;
`else
    lat_kind = KIND_K;
`endif
  end

  // Sticky overflow flag per lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_err <= '0;
    else     overflow_err <= overflow_err | (lane_req_valid & fifo_full);
  end

  // Request sequencer: latch a pair, issue k then l, pop and chain to the next winner without a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel_lane      <= '0;
      rr_ptr        <= LW'(LANES - 1);
      out_rn        <= '0;
      out_kind      <= KIND_K;
      out_addr      <= '0;
      lat_addr_l    <= '0;
      mem_req_valid <= 1'b0;
      req_count     <= '0;
    end else begin
      if (hs) req_count <= req_count + 32'd1;
      if (pair_done) begin
        rr_ptr <= sel_lane;
        if (any_post) begin
          sel_lane   <= lat_lane;
          out_rn     <= lat_rn;
          out_addr   <= lat_k;
          lat_addr_l <= lat_l;
          out_kind   <= lat_kind;
          state      <= ST_ISSUE_K;
        end else begin
          mem_req_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (any_ne) begin
              sel_lane      <= lat_lane;
              out_rn        <= lat_rn;
              out_addr      <= lat_k;
              lat_addr_l    <= lat_l;
              out_kind      <= lat_kind;
              mem_req_valid <= 1'b1;
              state         <= ST_ISSUE_K;
            end
          end
          ST_ISSUE_K: begin
            if (hs) begin
              out_addr <= lat_addr_l;
              out_kind <= KIND_L;
              state    <= ST_ISSUE_L;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bwd_mem_req_merge.sv
// tb/tb_bwd_mem_req_merge.sv - directed and randomized bench for bwd_mem_req_merge
module tb_bwd_mem_req_merge;

  localparam int LANES     = 4;
  localparam int ADDR_W    = 42;
  localparam int RN_W      = 10;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int LW        = 2;
  localparam int TAG_W     = LW + RN_W + 2;
`ifdef BWD_DEDUP_KL_EN
  localparam int EXP_DD_COUNT = 1;
`else
  localparam int EXP_DD_COUNT = 2;
`endif

  typedef struct packed {
    logic [RN_W-1:0]   rn;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] l;
  } ent_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [LANES-1:0]        lane_req_valid = '0;
  logic [LANES*ADDR_W-1:0] lane_addr_k = '0;
  logic [LANES*ADDR_W-1:0] lane_addr_l = '0;
  logic [LANES*RN_W-1:0]   lane_read_num = '0;
  logic [LANES-1:0]        lane_almost_full;
  logic [LANES-1:0]        overflow_err;
  logic                    mem_req_valid;
  logic                    mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [TAG_W-1:0]        mem_req_tag;
  logic [31:0]             req_count;
  logic                    busy;

  always #5 clk = ~clk;

  bwd_mem_req_merge #(
    .LANES(LANES), .ADDR_W(ADDR_W), .RN_W(RN_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .lane_req_valid   (lane_req_valid),
    .lane_addr_k      (lane_addr_k),
    .lane_addr_l      (lane_addr_l),
    .lane_read_num    (lane_read_num),
    .lane_almost_full (lane_almost_full),
    .overflow_err     (overflow_err),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_req_tag      (mem_req_tag),
    .req_count        (req_count),
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-lane queues plus the pair currently being offered
  ent_t             mq [LANES][$];
  ent_t             drv [LANES];
  int               m_last;
  bit               m_pend;
  int               m_lane;
  bit               m_half;
  ent_t             m_ent;
  logic [31:0]      m_count;
  logic [LANES-1:0] m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_dedup();
`ifdef BWD_DEDUP_KL_EN
    return m_ent.k == m_ent.l;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) mq[i].delete();
    m_last  = LANES - 1;
    m_pend  = 1'b0;
    m_lane  = 0;
    m_half  = 1'b0;
    m_count = '0;
    m_ovf   = '0;
  endtask

  task automatic model_select();
    m_pend = 1'b0;
    for (int k = 1; k <= LANES; k++) begin
      int idx;
      idx = (m_last + k) % LANES;
      if (!m_pend && mq[idx].size() > 0) begin
        m_pend = 1'b1;
        m_lane = idx;
        m_ent  = mq[idx][0];
        m_half = 1'b0;
      end
    end
  endtask

  task automatic model_handshake();
    m_count = m_count + 32'd1;
    if (m_half || m_dedup()) begin
      void'(mq[m_lane].pop_front());
      m_last = m_lane;
      model_select();
    end else begin
      m_half = 1'b1;
    end
  endtask

  function automatic logic [LANES-1:0] exp_af();
    logic [LANES-1:0] af;
    for (int i = 0; i < LANES; i++) af[i] = (mq[i].size() >= DEPTH - AF_MARGIN);
    return af;
  endfunction

  task automatic rand_drv(input int lane);
    drv[lane].rn = RN_W'($urandom);
    drv[lane].k  = ADDR_W'({$urandom, $urandom});
    drv[lane].l  = ($urandom_range(0, 3) == 0) ? drv[lane].k : ADDR_W'({$urandom, $urandom});
  endtask

  // Present one push cycle to the DUT and mirror it in the model
  task automatic drive_push(input logic [LANES-1:0] mask);
    lane_req_valid = mask;
    for (int i = 0; i < LANES; i++) begin
      lane_read_num[i*RN_W +: RN_W]   = drv[i].rn;
      lane_addr_k[i*ADDR_W +: ADDR_W] = drv[i].k;
      lane_addr_l[i*ADDR_W +: ADDR_W] = drv[i].l;
      if (mask[i]) begin
        if (mq[i].size() >= DEPTH) m_ovf[i] = 1'b1;
        else mq[i].push_back(drv[i]);
      end
    end
    if (!m_pend) model_select();
  endtask

  // One clock of checking against the model with a chosen ready value
  task automatic cyc(input bit rdy);
    logic [1:0]        kind;
    logic [ADDR_W-1:0] ea;
    kind = m_dedup() ? 2'b10 : {1'b0, m_half};
    ea   = m_half ? m_ent.l : m_ent.k;
    check("valid", mem_req_valid, m_pend);
    if (m_pend) begin
      check("addr", mem_req_addr, ea);
      check("tag", mem_req_tag, {LW'(m_lane), m_ent.rn, kind});
    end
    check("almost_full", lane_almost_full, exp_af());
    mem_req_ready = rdy;
    if (rdy && m_pend) model_handshake();
    @(negedge clk);
  endtask

  task automatic drain(input int ready_pct);
    int n;
    n = 0;
    while ((m_pend || mem_req_valid) && n < 400) begin
      cyc($urandom_range(0, 99) < ready_pct);
      n++;
    end
    mem_req_ready = 1'b0;
    check("drain_bound", n < 400, 1'b1);
    check("idle_valid", mem_req_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("req_count", req_count, m_count);
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lane_req_valid = '0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < LANES; i++) drv[i] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", mem_req_valid, 1'b0);
    check("rst_addr", mem_req_addr, '0);
    check("rst_tag", mem_req_tag, '0);
    check("rst_count", req_count, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_af", lane_almost_full, '0);
    check("rst_ovf", overflow_err, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single push on lane 2: two-cycle latency, k then l
    drv[2] = '{rn: 10'd5, k: 42'h100, l: 42'h140};
    mem_req_ready = 1'b1;
    drive_push(4'b0100);
    @(negedge clk);
    lane_req_valid = '0;
    check("lat_cycle1_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_valid", mem_req_valid, 1'b1);
    check("single_tag_k", mem_req_tag, 14'b10_0000000101_00);
    check("single_addr_k", mem_req_addr, 42'h100);
    drain(100);
    check("single_count", req_count, 32'd2);

    // All lanes at once: grant order 0..3, eight back-to-back handshakes
    do_reset();
    for (int i = 0; i < LANES; i++) rand_drv(i);
    drive_push(4'hF);
    @(negedge clk);
    lane_req_valid = '0;
    @(negedge clk);
    check("all_first_lane", mem_req_tag[TAG_W-1 -: LW], 2'd0);
    drain(100);
    check("all_count", req_count, 32'd8);

    // Stalls in both halves of a pair; lane 1 holds 6 so almost_full must stay up until l accepted
    do_reset();
    for (int j = 0; j < 6; j++) begin
      rand_drv(1);
      drive_push(4'b0010);
      @(negedge clk);
    end
    lane_req_valid = '0;
    @(negedge clk);
    for (int j = 0; j < 5; j++) cyc(1'b0);
    cyc(1'b1);
    for (int j = 0; j < 5; j++) cyc(1'b0);
    cyc(1'b1);
    check("stall_af_after_pop", lane_almost_full[1], 1'b0);
    drain(60);

    // Overflow on lane 1 with ready held low
    do_reset();
    for (int j = 1; j <= 9; j++) begin
      rand_drv(1);
      drive_push(4'b0010);
      @(negedge clk);
      check("ovf_af", lane_almost_full[1], j >= 6);
      check("ovf_err", overflow_err[1], j == 9);
    end
    lane_req_valid = '0;
    drain(100);
    check("ovf_drain_count", req_count, 32'd16);

    // Asynchronous reset while in the l half with entries queued
    do_reset();
    for (int i = 0; i < LANES; i++) rand_drv(i);
    drive_push(4'b0111);
    @(negedge clk);
    lane_req_valid = '0;
    @(negedge clk);
    cyc(1'b1);
    cyc(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", mem_req_valid, 1'b0);
    check("midrst_count", req_count, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tag", mem_req_tag, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rand_drv(3);
    drive_push(4'b1000);
    @(negedge clk);
    lane_req_valid = '0;
    @(negedge clk);
    check("midrst_fresh_lane", mem_req_tag[TAG_W-1 -: LW], 2'd3);
    drain(100);

    // k == l on the same request
    do_reset();
    drv[0] = '{rn: 10'd9, k: 42'h200, l: 42'h200};
    drive_push(4'b0001);
    @(negedge clk);
    lane_req_valid = '0;
    @(negedge clk);
    drain(100);
    check("dedup_count", req_count, EXP_DD_COUNT);

    // Randomized bursts followed by drains with random backpressure
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int blen;
      blen = $urandom_range(1, 6);
      for (int b = 0; b < blen; b++) begin
        check("burst_af", lane_almost_full, exp_af());
        for (int i = 0; i < LANES; i++) rand_drv(i);
        drive_push(LANES'($urandom));
        @(negedge clk);
      end
      lane_req_valid = '0;
      @(negedge clk);
      drain($urandom_range(30, 100));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
